button_cmd_arbiter: RTL and testbench



---
 rtl/button_cmd_arbiter_pkg.sv | 45 ++++
 rtl/button_cmd_arbiter_btn_sync.sv | 27 ++
 rtl/button_cmd_arbiter.sv | 135 +++++++++++++
 tb/tb_button_cmd_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/button_cmd_arbiter_pkg.sv
// Shared definitions for the push-button command arbiter: button indices,
// command codes, FSM states and small priority helpers.
package button_cmd_arbiter_pkg;

  localparam int NUM_BTN = 5;

  // Bit positions in the button vector; lower index means higher priority.
  localparam int BTN_CLR   = 0;
  localparam int BTN_MODE  = 1;
  localparam int BTN_SHIFT = 2;
  localparam int BTN_INC   = 3;
  localparam int BTN_SS    = 4;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLR   = 3'd1,
    CMD_MODE  = 3'd2,
    CMD_SHIFT = 3'd3,
    CMD_INC   = 3'd4,
    CMD_SS    = 3'd5
  } cmd_code_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  // Isolates the highest-priority (lowest-index) pressed button.
  function automatic logic [NUM_BTN-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    return v & (~v + NUM_BTN'(1));
  endfunction

  // Button index i maps to command code i+1.
  function automatic cmd_code_e code_of(input logic [NUM_BTN-1:0] onehot);
    cmd_code_e c;
    c = CMD_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (onehot[i]) c = cmd_code_e'(3'(i + 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/button_cmd_arbiter_btn_sync.sv
// Multi-flop synchronizer for the raw button vector, cleared by synchronous reset.
module button_cmd_arbiter_btn_sync
  import button_cmd_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = NUM_BTN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign synced = stage[SYNC_STAGES-1];

endmodule

// File: rtl/button_cmd_arbiter.sv
// Push-button front end: synchronizes five buttons, arbitrates by fixed
// priority, qualifies by hold time and emits one-cycle command strobes.
module button_cmd_arbiter
  import button_cmd_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES   = 15_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_clr,
  input  logic       btn_shift,
  input  logic       btn_inc,
  input  logic       btn_ss,
  output logic       cmd_mode,
  output logic       cmd_clr,
  output logic       cmd_shift,
  output logic       cmd_inc,
  output logic       cmd_ss,
  output logic [2:0] cmd_code,
  output logic       busy
);

  localparam int CNT_W  = $clog2(HOLD_CYCLES);
  localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] s;

  assign raw[BTN_CLR]   = btn_clr;
  assign raw[BTN_MODE]  = btn_mode;
  assign raw[BTN_SHIFT] = btn_shift;
  assign raw[BTN_INC]   = btn_inc;
  assign raw[BTN_SS]    = btn_ss;

  button_cmd_arbiter_btn_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_BTN)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw),
    .synced (s)
  );

  state_e             state, state_nxt;
  logic [NUM_BTN-1:0] win, win_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RCNT_W-1:0]  rcnt, rcnt_nxt;
  logic [NUM_BTN-1:0] strobe, strobe_nxt;
  cmd_code_e          code, code_nxt;

  // Strobes are registered, so a fire decided in cycle t0+HOLD-1 shows at t0+HOLD.
  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    cnt_nxt    = cnt;
    rcnt_nxt   = rcnt;
    strobe_nxt = '0;
    code_nxt   = code;
    case (state)
      IDLE: begin
        if (|s) begin
          win_nxt   = lowest_set(s);
          cnt_nxt   = CNT_W'(1);
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (!(|(s & win))) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == HOLD_LAST) begin
          strobe_nxt = win;
          code_nxt   = code_of(win);
          cnt_nxt    = '0;
          if (win[BTN_INC]) begin
            rcnt_nxt  = '0;
            state_nxt = REPEAT;
          end else begin
            state_nxt = WAIT_REL;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!s[BTN_INC]) begin
          rcnt_nxt  = '0;
          state_nxt = WAIT_REL;
        end else if (rcnt == REP_LAST) begin
          strobe_nxt = win;
          rcnt_nxt   = '0;
        end else begin
          rcnt_nxt = rcnt + RCNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!(|s)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      win    <= '0;
      cnt    <= '0;
      rcnt   <= '0;
      strobe <= '0;
      code   <= CMD_NONE;
    end else begin
      state  <= state_nxt;
      win    <= win_nxt;
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      strobe <= strobe_nxt;
      code   <= code_nxt;
    end
  end

  assign cmd_clr   = strobe[BTN_CLR];
  assign cmd_mode  = strobe[BTN_MODE];
  assign cmd_shift = strobe[BTN_SHIFT];
  assign cmd_inc   = strobe[BTN_INC];
  assign cmd_ss    = strobe[BTN_SS];
  assign cmd_code  = code;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Directed bench for button_cmd_arbiter with HOLD=4, REPEAT=3, SYNC=2.
module tb_button_cmd_arbiter;

  localparam int HOLD = 4;
  localparam int REP  = 3;
  localparam int SYNC = 2;
  localparam int WIN  = 20;

  // Bench-side bit order: {ss, inc, shift, mode, clr}
  localparam logic [4:0] B_CLR   = 5'b00001;
  localparam logic [4:0] B_MODE  = 5'b00010;
  localparam logic [4:0] B_SHIFT = 5'b00100;
  localparam logic [4:0] B_INC   = 5'b01000;
  localparam logic [4:0] B_SS    = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_vec;
  logic       cmd_mode, cmd_clr, cmd_shift, cmd_inc, cmd_ss, busy;
  logic [2:0] cmd_code;
  logic [4:0] strobes;

  assign strobes = {cmd_ss, cmd_inc, cmd_shift, cmd_mode, cmd_clr};

  always #5 clk = ~clk;

  button_cmd_arbiter #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .btn_mode  (btn_vec[1]),
    .btn_clr   (btn_vec[0]),
    .btn_shift (btn_vec[2]),
    .btn_inc   (btn_vec[3]),
    .btn_ss    (btn_vec[4]),
    .cmd_mode  (cmd_mode),
    .cmd_clr   (cmd_clr),
    .cmd_shift (cmd_shift),
    .cmd_inc   (cmd_inc),
    .cmd_ss    (cmd_ss),
    .cmd_code  (cmd_code),
    .busy      (busy)
  );

  typedef struct {
    string      name;
    logic [4:0] btn;
    int         hold;       // synced cycles the buttons stay high
    logic [4:0] fire_mask;  // strobe expected when a fire occurs
    logic [19:0] fire_at;   // offsets (from t0) where a strobe is expected
    int         code;       // cmd_code from the first fire on
    int         busy_last;  // busy high for offsets 1..busy_last
  } vec_t;

  vec_t vecs [9];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int fire_cyc = -1;
  int fire_cnt [5];
  int prev_code = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Drive inputs for the current cycle, advance one cycle and record strobes.
  task automatic step(input logic [4:0] b, input logic r);
    btn_vec = b;
    rst     = r;
    @(negedge clk);
    ncyc++;
    for (int i = 0; i < 5; i++) begin
      if (strobes[i]) begin
        fire_cnt[i]++;
        fire_cyc = ncyc;
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) fire_cnt[i] = 0;
    fire_cyc = -1;
  endtask

  initial begin
    vecs[0] = '{"short_inc",   B_INC,          3, 5'b0,  20'h00000, 0, 3};
    vecs[1] = '{"long_mode",   B_MODE,        10, B_MODE, 20'h00010, 2, 10};
    vecs[2] = '{"repeat_inc",  B_INC,         12, B_INC, 20'h00490, 4, 13};
    vecs[3] = '{"simul_clr",   B_CLR | B_MODE, 6, B_CLR, 20'h00010, 1, 6};
    vecs[4] = '{"exact_shift", B_SHIFT,        4, B_SHIFT, 20'h00010, 3, 4};
    vecs[5] = '{"short_ss",    B_SS,           3, 5'b0,  20'h00000, 0, 3};
    vecs[6] = '{"long_ss",     B_SS,           5, B_SS,  20'h00010, 5, 5};
    vecs[7] = '{"inc_two",     B_INC,          7, B_INC, 20'h00090, 4, 8};
    vecs[8] = '{"inc_one",     B_INC,          6, B_INC, 20'h00010, 4, 7};

    btn_vec = '0;
    rst     = 1'b1;
    clear_counts();
    @(negedge clk);
    step(5'b0, 1'b1);
    step(5'b0, 1'b1);
    step(5'b0, 1'b0);
    chk("reset_strobes", int'(strobes), 0);
    chk("reset_code", int'(cmd_code), 0);
    chk("reset_busy", int'(busy), 0);

    // Table-driven single-press scenarios; offset k = call index - 1.
    for (int v = 0; v < 9; v++) begin
      logic [19:0] fa;
      fa = vecs[v].fire_at;
      for (int j = 0; j <= WIN; j++) begin
        int k;
        int exp_code;
        step((j < vecs[v].hold) ? vecs[v].btn : 5'b0, 1'b0);
        k = j - 1;
        if (k >= 0) begin
          exp_code = (vecs[v].fire_mask != 0 && k >= HOLD) ? vecs[v].code : prev_code;
          chk({vecs[v].name, "_strobe"}, int'(strobes), fa[k] ? int'(vecs[v].fire_mask) : 0);
          chk({vecs[v].name, "_busy"}, int'(busy), (k >= 1 && k <= vecs[v].busy_last) ? 1 : 0);
          chk({vecs[v].name, "_code"}, int'(cmd_code), exp_code);
        end
      end
      if (vecs[v].fire_mask != 0) prev_code = vecs[v].code;
    end

    // Press during hold: inc pressed while mode held must never fire.
    clear_counts();
    repeat (3) step(B_MODE, 1'b0);
    repeat (7) step(B_MODE | B_INC, 1'b0);
    repeat (10) step(B_INC, 1'b0);
    repeat (5) step(5'b0, 1'b0);
    chk("hold_mode_count", fire_cnt[1], 1);
    chk("hold_inc_count", fire_cnt[3], 0);
    chk("hold_clr_count", fire_cnt[0], 0);
    chk("hold_code", int'(cmd_code), 2);
    chk("hold_busy_after", int'(busy), 0);

    begin
      int base;
      clear_counts();
      base = ncyc;
      repeat (4) step(B_INC, 1'b0);
      repeat (8) step(5'b0, 1'b0);
      chk("repress_inc_count", fire_cnt[3], 1);
      chk("repress_inc_cycle", fire_cyc, base + 2 + HOLD);
      chk("repress_code", int'(cmd_code), 4);
    end

    // Reset mid-ARM at t0+2.
    begin
      int base;
      clear_counts();
      base = ncyc;
      repeat (4) step(B_SS, 1'b0);
      chk("rst_arm_busy", int'(busy), 1);
      step(5'b0, 1'b1);
      chk("rst_after_busy", int'(busy), 0);
      chk("rst_after_code", int'(cmd_code), 0);
      chk("rst_after_strobes", int'(strobes), 0);
      repeat (10) step(5'b0, 1'b0);
      chk("rst_no_ss", fire_cnt[4], 0);
      chk("rst_idle_code", int'(cmd_code), 0);

      clear_counts();
      base = ncyc;
      repeat (5) step(B_SS, 1'b0);
      repeat (6) step(5'b0, 1'b0);
      chk("rearm_ss_count", fire_cnt[4], 1);
      chk("rearm_ss_cycle", fire_cyc, base + 2 + HOLD);
      chk("rearm_code", int'(cmd_code), 5);
      chk("rearm_busy", int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
